// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and default datapath widths.
package mul_div_unit_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int ADDR_W_DEF = 3;

    // Same encoding the core decoder drives onto the op port
    typedef enum logic [1:0] {
        MUL_LO = 2'b00,
        MUL_HI = 2'b01,
        DIV_Q  = 2'b10,
        DIV_R  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// Iteration engine: shift-add multiplier and restoring divider that advance one
// bit per step, plus the iteration counter.
module mul_div_datapath
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] prod_nxt,
    output logic [WIDTH-1:0]   quot_nxt,
    output logic [WIDTH-1:0]   rem_nxt
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quot_step;

    always_comb begin
        // Multiply: the multiplier sits in the low half and is consumed from bit 0
        // while the growing product shifts in from the top with the adder carry.
        add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
        prod_step = {add_sum, prod_q[WIDTH-1:1]};

        // Divide: the dividend shifts out of quot_q MSB-first while quotient bits fill in at the LSB.
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor_q};
        rem_step  = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        quot_step = {quot_q[WIDTH-2:0], ~rem_diff[WIDTH]};

        prod_d    = prod_q;
        mcand_d   = mcand_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;

        if (load) begin
            prod_d    = {{WIDTH{1'b0}}, b};
            mcand_d   = a;
            rem_d     = '0;
            quot_d    = a;
            divisor_d = b;
            cnt_d     = '0;
        end else if (step) begin
            prod_d = prod_step;
            rem_d  = rem_step;
            quot_d = quot_step;
            cnt_d  = cnt_q + CNT_W'(1);
        end

        last     = (cnt_q == CNT_W'(WIDTH - 1));
        prod_nxt = prod_step;
        quot_nxt = quot_step;
        rem_nxt  = rem_step;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q    <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else begin
            prod_q    <= prod_d;
            mcand_q   <= mcand_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: control FSM and registered
// register-file write port around the iteration datapath.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [ADDR_W-1:0] dest,
    output logic              busy,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]  wb_data_q, wb_data_d;

    logic               dp_load;
    logic               dp_step;
    logic               dp_last;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   quot_nxt;
    logic [WIDTH-1:0]   rem_nxt;

    mul_div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (dp_load),
        .step     (dp_step),
        .a        (a),
        .b        (b),
        .last     (dp_last),
        .prod_nxt (prod_nxt),
        .quot_nxt (quot_nxt),
        .rem_nxt  (rem_nxt)
    );

    // The write registers load on the edge that enters DONE, so wb_en is high exactly in DONE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dest_d    = dest_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        dp_load   = 1'b0;
        dp_step   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    dest_d  = dest;
                    dp_load = 1'b1;
                    if (is_div(op) && (b == '0)) begin
                        state_d   = DONE;
                        wb_en_d   = 1'b1;
                        wb_addr_d = dest;
                        wb_data_d = (op_e'(op) == DIV_Q) ? {WIDTH{1'b1}} : a;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                dp_step = 1'b1;
                if (dp_last) begin
                    state_d   = DONE;
                    wb_en_d   = 1'b1;
                    wb_addr_d = dest_q;
                    unique case (op_q)
                        MUL_LO:  wb_data_d = prod_nxt[WIDTH-1:0];
                        MUL_HI:  wb_data_d = prod_nxt[2*WIDTH-1:WIDTH];
                        DIV_Q:   wb_data_d = quot_nxt;
                        DIV_R:   wb_data_d = rem_nxt;
                        default: wb_data_d = wb_data_q;
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= MUL_LO;
            dest_q    <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dest_q    <= dest_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops against a
// behavioural model, and hand-written re-start and mid-operation reset sequences.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [AW-1:0] dest;
  logic          busy;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;

  mul_div_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .dest    (dest),
    .busy    (busy),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // scoreboard: {addr, data}, expected latency, issue cycle
  logic [AW+W-1:0] exp_q[$];
  int              lat_q[$];
  int              iss_q[$];

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] dest;
    logic [W-1:0]  exp_data;
    int            exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (bv == 0) ? {W{1'b1}} : av / bv;
      default: return (bv == 0) ? av : av % bv;
    endcase
  endfunction

  // monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write (cyc=%0d)", wb_addr, wb_data, cyc);
      end else begin
        logic [AW+W-1:0] e;
        int el;
        int ic;
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        ic = iss_q.pop_front();
        check("wb_data", 32'(wb_data), 32'(e[W-1:0]));
        check("wb_addr", 32'(wb_addr), 32'(e[AW+W-1:W]));
        check("wb_latency", 32'(cyc - ic), 32'(el));
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [AW-1:0] d, input bit push, input logic [W-1:0] ed, input int el);
    op    = o;
    a     = av;
    b     = bv;
    dest  = d;
    start = 1'b1;
    if (push) begin
      exp_q.push_back({d, ed});
      lat_q.push_back(el);
      iss_q.push_back(cyc);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check(name, 32'(busy), 32'd0);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [AW-1:0] d, input logic [W-1:0] ed, input int el);
    int n;
    issue(o, av, bv, d, 1'b1, ed, el);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    dest  = AW'($urandom);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'(el));
  endtask

  initial begin
    int k;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0]  = '{2'b00, 16'h1234, 16'h0010, 3'd3, 16'h2340, 17};
    vecs[1]  = '{2'b01, 16'hFFFF, 16'hFFFF, 3'd5, 16'hFFFE, 17};
    vecs[2]  = '{2'b00, 16'hFFFF, 16'hFFFF, 3'd5, 16'h0001, 17};
    vecs[3]  = '{2'b10, 16'd100,  16'd7,    3'd2, 16'h000E, 17};
    vecs[4]  = '{2'b11, 16'd100,  16'd7,    3'd2, 16'h0002, 17};
    vecs[5]  = '{2'b10, 16'h0055, 16'h0000, 3'd1, 16'hFFFF, 1};
    vecs[6]  = '{2'b11, 16'h0055, 16'h0000, 3'd1, 16'h0055, 1};
    vecs[7]  = '{2'b01, 16'h1234, 16'h0010, 3'd0, 16'h0001, 17};
    vecs[8]  = '{2'b10, 16'hFFFF, 16'h0001, 3'd6, 16'hFFFF, 17};
    vecs[9]  = '{2'b11, 16'h0007, 16'hFFFF, 3'd7, 16'h0007, 17};
    vecs[10] = '{2'b10, 16'h0003, 16'h0009, 3'd4, 16'h0000, 17};
    vecs[11] = '{2'b01, 16'h8000, 16'h0002, 3'd2, 16'h0001, 17};

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    dest  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wb_en", 32'(wb_en), 32'd0);
    check("reset_wb_addr", 32'(wb_addr), 32'd0);
    check("reset_wb_data", 32'(wb_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].exp_data, vecs[i].exp_lat);
      check("wb_en_drop", 32'(wb_en), 32'd0);
    end

    // start re-pulsed during RUN (cycle 3) and DONE (cycle 17); then a start right after wb_en
    wait_idle("idle_before_repulse");
    k = cyc;
    issue(2'b00, 16'h1234, 16'h0010, 3'd3, 1'b1, 16'h2340, 17);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 3) @(negedge clk);
    issue(2'b01, 16'hFFFF, 16'hFFFF, 3'd7, 1'b0, 16'h0000, 0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 17) @(negedge clk);
    check("repulse_wb_en_at_17", 32'(wb_en), 32'd1);
    issue(2'b11, 16'h0009, 16'h0002, 3'd6, 1'b0, 16'h0000, 0);
    @(negedge clk);
    check("repulse_idle_after_done", 32'(busy), 32'd0);
    issue(2'b10, 16'd100, 16'd7, 3'd2, 1'b1, 16'h000E, 17);
    @(negedge clk);
    start = 1'b0;
    check("back_to_back_accepted", 32'(busy), 32'd1);
    wait_idle("repulse_drain_timeout");
    check("repulse_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a divide loses the operation
    k = cyc;
    issue(2'b10, 16'd100, 16'd7, 3'd4, 1'b0, 16'h0000, 0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 8) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_write", 32'(exp_q.size()), 32'd0);
    do_op(2'b00, 16'd3, 16'd4, 3'd1, 16'h000C, 17);

    // random operations against the behavioural model
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 1) == 1) rb = W'($urandom_range(1, 255));
      do_op(ro, ra, rb, AW'($urandom), model(ro, ra, rb),
            (ro[1] && rb == '0) ? 1 : 17);
    end

    // wb_data holds after the write; wb_en has returned low
    repeat (3) @(negedge clk);
    check("hold_wb_en", 32'(wb_en), 32'd0);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
